// File: rtl/reg_writeback.sv
// Write-back queue owning the register file write port, with two-port forwarding of pending writes.
// Latency: a push accepted at edge N is committed at edge N+1 (hold low); forwarding is combinational.
// Backpressure: in_ready drops only when all DEPTH entries are occupied; hold stalls retirement only.
module reg_writeback #(
    parameter int DEPTH    = 4,
    parameter int AW       = 5,
    parameter int DW       = 32,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     hold,
    output logic                     wr_en,
    output logic [AW-1:0]            wr_addr,
    output logic [DW-1:0]            wr_data,
    input  logic [AW-1:0]            rd_addr1,
    input  logic [AW-1:0]            rd_addr2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [DW-1:0]            fwd_data1,
    output logic [DW-1:0]            fwd_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] addr_mem_q [DEPTH];
    logic [AW-1:0] addr_mem_d [DEPTH];
    logic [DW-1:0] data_mem_q [DEPTH];
    logic [DW-1:0] data_mem_d [DEPTH];

    logic push;
    logic enq;
    logic pop;
    logic zero_drop;
    logic excl1;
    logic excl2;
    logic [PW-1:0] slot;

    always_comb begin
        in_ready  = (count_q < FULL);
        wr_en     = (count_q != '0) && !hold;
        wr_addr   = addr_mem_q[head_q];
        wr_data   = data_mem_q[head_q];
        push      = in_valid && in_ready;
        // Writes to the hardwired zero register complete the handshake but never occupy a slot.
        zero_drop = (ZERO_REG != 0) && (in_addr == '0);
        enq       = push && !zero_drop;
        pop       = wr_en;

        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;

        if (enq) begin
            addr_mem_d[tail_q] = in_addr;
            data_mem_d[tail_q] = in_data;
            tail_d             = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        unique case ({enq, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to youngest so the last match seen is the youngest pending value.
    always_comb begin
        excl1     = (ZERO_REG != 0) && (rd_addr1 == '0);
        excl2     = (ZERO_REG != 0) && (rd_addr2 == '0);
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        slot      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (!excl1 && (addr_mem_q[slot] == rd_addr1)) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = data_mem_q[slot];
                end
                if (!excl2 && (addr_mem_q[slot] == rd_addr2)) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = data_mem_q[slot];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payloads carry no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
    end

    assign count = count_q;

endmodule

// File: tb/tb_reg_writeback.sv
`timescale 1ns/1ps
module tb_reg_writeback;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          hold;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic          fwd_hit1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data1;
    logic [DW-1:0] fwd_data2;
    logic [2:0]    count;

    reg_writeback #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .ZERO_REG(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .hold      (hold),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_commits = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference: pending writes are an ordered list; commit from the front, youngest match forwards.
    always @(negedge clk) begin
        int   sz;
        logic exp_wr;
        logic h1, h2;
        logic [DW-1:0] d1, d2;
        if (rst) begin
            mq.delete();
        end else begin
            sz     = mq.size();
            exp_wr = (sz != 0) && !hold;
            chk("count", 64'(count), 64'(sz));
            chk("in_ready", 64'(in_ready), 64'(sz < DEPTH));
            chk("wr_en", 64'(wr_en), 64'(exp_wr));
            h1 = 1'b0; h2 = 1'b0; d1 = '0; d2 = '0;
            foreach (mq[k]) begin
                if (rd_addr1 != 0 && mq[k].a == rd_addr1) begin h1 = 1'b1; d1 = mq[k].d; end
                if (rd_addr2 != 0 && mq[k].a == rd_addr2) begin h2 = 1'b1; d2 = mq[k].d; end
            end
            chk("fwd_hit1", 64'(fwd_hit1), 64'(h1));
            chk("fwd_data1", 64'(fwd_data1), 64'(d1));
            chk("fwd_hit2", 64'(fwd_hit2), 64'(h2));
            chk("fwd_data2", 64'(fwd_data2), 64'(d2));
            if (exp_wr) begin
                if (wr_en) begin
                    chk("wr_addr", 64'(wr_addr), 64'(mq[0].a));
                    chk("wr_data", 64'(wr_data), 64'(mq[0].d));
                end
                n_commits++;
                void'(mq.pop_front());
            end
            if (in_valid && sz < DEPTH && in_addr != 0) begin
                mq.push_back('{a: in_addr, d: in_data});
            end
        end
    end

    task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic h, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic r);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        hold     = h;
        rd_addr1 = r1;
        rd_addr2 = r2;
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; hold = 1'b0;
        rd_addr1 = '0; rd_addr2 = '0;
        repeat (2) @(posedge clk);
        #1;

        // Single push, one-cycle commit
        step(1, 5'd3, 32'hDEADBEEF, 0, 5'd3, 5'd0, 0);
        step(0, 5'd0, 32'h0, 0, 5'd3, 5'd0, 0);
        step(0, 5'd0, 32'h0, 0, 5'd3, 5'd0, 0);

        // Fill under hold, overflow push refused, then drain in order
        for (int k = 1; k <= 4; k++) step(1, AW'(k), 32'h100 + DW'(k), 1, AW'(k), 5'd5, 0);
        for (int k = 0; k < 3; k++)  step(1, 5'd5, 32'h5555, 1, 5'd2, 5'd5, 0);
        for (int k = 0; k < 2; k++)  step(1, 5'd5, 32'h5555, 0, 5'd3, 5'd5, 0);
        for (int k = 0; k < 5; k++)  step(0, 5'd0, 32'h0, 0, 5'd4, 5'd5, 0);

        // Youngest match forwards
        step(1, 5'd7, 32'h11, 1, 5'd7, 5'd8, 0);
        step(1, 5'd7, 32'h22, 1, 5'd7, 5'd8, 0);
        step(0, 5'd0, 32'h0, 1, 5'd7, 5'd8, 0);
        for (int k = 0; k < 3; k++) step(0, 5'd0, 32'h0, 0, 5'd7, 5'd8, 0);

        // Zero-register write is swallowed
        step(1, 5'd0, 32'h55, 0, 5'd0, 5'd0, 0);
        step(0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 0);
        step(0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 0);

        // Back-to-back streaming across pointer wrap
        for (int k = 1; k <= 10; k++) step(1, AW'(k), DW'(k), 0, AW'(k), AW'(k - 1), 0);
        step(0, 5'd0, 32'h0, 0, 5'd10, 5'd9, 0);
        step(0, 5'd0, 32'h0, 0, 5'd10, 5'd9, 0);

        // Reset with three pending entries
        for (int k = 0; k < 3; k++) step(1, AW'(20 + k), 32'hA0 + DW'(k), 1, 5'd21, 5'd22, 0);
        step(0, 5'd0, 32'h0, 1, 5'd21, 5'd22, 1);
        for (int k = 0; k < 4; k++) step(0, 5'd0, 32'h0, 0, 5'd21, 5'd22, 0);

        // Randomized traffic with narrow address range to provoke forwarding collisions
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), DW'($urandom),
                 $urandom_range(0, 3) == 0, AW'($urandom_range(0, 7)),
                 AW'($urandom_range(0, 7)), $urandom_range(0, 199) == 0);
        end
        for (int k = 0; k < 6; k++) step(0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 0);

        chk("commits_seen", 64'(n_commits > 100), 64'(1));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
